// File: rtl/lsu_sram_bridge_if.sv
// Signal bundles on either side of the LSU data-side SRAM bridge:
// the LSU request/response handshake and the SRAM-like data port.
interface lsu_bus_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [ADDR_W-1:0] lsu_req_addr;
  logic [DATA_W-1:0] lsu_req_wdata;
  logic [3:0]        lsu_req_strobe;
  logic              lsu_req_write_en;
  logic              lsu_resp_valid;
  logic              lsu_resp_ready;
  logic [DATA_W-1:0] lsu_resp_data;

  modport master (
    output lsu_req_valid, lsu_req_addr, lsu_req_wdata, lsu_req_strobe,
           lsu_req_write_en, lsu_resp_ready,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_data
  );

  modport slave (
    input  lsu_req_valid, lsu_req_addr, lsu_req_wdata, lsu_req_strobe,
           lsu_req_write_en, lsu_resp_ready,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_data
  );
endinterface

interface sram_bus_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              sram_req;
  logic              sram_wr;
  logic [1:0]        sram_size;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic              sram_addr_ok;
  logic              sram_data_ok;
  logic [DATA_W-1:0] sram_rdata;

  modport master (
    output sram_req, sram_wr, sram_size, sram_addr, sram_wdata,
    input  sram_addr_ok, sram_data_ok, sram_rdata
  );

  modport slave (
    input  sram_req, sram_wr, sram_size, sram_addr, sram_wdata,
    output sram_addr_ok, sram_data_ok, sram_rdata
  );
endinterface

// File: rtl/lsu_sram_bridge.sv
// LSU-to-SRAM-like data port bridge: one outstanding transfer, strobe-to-size
// translation, store data lane placement and a single-entry read response hold.
module lsu_sram_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  lsu_bus_if.slave    lsu,
  sram_bus_if.master  sram,
  output logic        bridge_busy,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);

  typedef enum logic [1:0] {IDLE, WAIT_RD, WAIT_WR, HOLD} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [31:0]       rd_count_q, rd_count_d;
  logic [31:0]       wr_count_q, wr_count_d;

  logic              req_ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              issue;
  logic [1:0]        size;

  // Single-lane strobes are bytes, the two aligned pairs are halves,
  // anything else is treated as a full word.
  function automatic logic [1:0] strobe_to_size(input logic [3:0] strobe);
    case (strobe)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: strobe_to_size = 2'd0;
      4'b0011, 4'b1100:                   strobe_to_size = 2'd1;
      default:                            strobe_to_size = 2'd2;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] place_wdata(input logic [DATA_W-1:0] wdata,
                                                    input logic [1:0]        sz,
                                                    input logic [1:0]        offset);
    case (sz)
      2'd0:    place_wdata = wdata << {offset, 3'b000};
      2'd1:    place_wdata = wdata << {offset[1], 4'b0000};
      default: place_wdata = wdata;
    endcase
  endfunction

  // Address-phase fields follow the LSU request directly; only sram_req is gated by state.
  assign size            = lsu.lsu_req_write_en ? strobe_to_size(lsu.lsu_req_strobe) : 2'd2;
  assign sram.sram_wr    = lsu.lsu_req_write_en;
  assign sram.sram_size  = size;
  assign sram.sram_addr  = lsu.lsu_req_write_en ? lsu.lsu_req_addr
                                                : {lsu.lsu_req_addr[ADDR_W-1:2], 2'b00};
  assign sram.sram_wdata = place_wdata(lsu.lsu_req_wdata, size, lsu.lsu_req_addr[1:0]);
  assign sram.sram_req   = issue;

  assign lsu.lsu_req_ready  = req_ready;
  assign lsu.lsu_resp_valid = resp_valid;
  assign lsu.lsu_resp_data  = resp_data;

  assign bridge_busy = (state_q != IDLE);
  assign rd_count    = rd_count_q;
  assign wr_count    = wr_count_q;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    issue      = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;
    case (state_q)
      IDLE: begin
        issue     = lsu.lsu_req_valid;
        req_ready = lsu.lsu_req_valid & sram.sram_addr_ok;
        if (req_ready) begin
          state_d = lsu.lsu_req_write_en ? WAIT_WR : WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (sram.sram_data_ok) begin
          if (lsu.lsu_resp_ready) begin
            resp_valid = 1'b1;
            resp_data  = sram.sram_rdata;
            rd_count_d = rd_count_q + 32'd1;
            state_d    = IDLE;
          end else begin
            hold_d  = sram.sram_rdata;
            state_d = HOLD;
          end
        end
      end
      WAIT_WR: begin
        if (sram.sram_data_ok) begin
          wr_count_d = wr_count_q + 32'd1;
          state_d    = IDLE;
        end
      end
      HOLD: begin
        resp_valid = 1'b1;
        resp_data  = hold_q;
        if (lsu.lsu_resp_ready) begin
          rd_count_d = rd_count_q + 32'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

endmodule

// File: tb/tb_lsu_sram_bridge.sv
// Directed and randomized transactions for lsu_sram_bridge, checked against a
// transaction-level model of sizes, lane placement, response timing and counts.
module tb_lsu_sram_bridge;

  logic        clk;
  logic        rst;
  logic        busy;
  logic [31:0] rd_count;
  logic [31:0] wr_count;

  int tests = 0;
  int fails = 0;
  int exp_rd = 0;
  int exp_wr = 0;

  lsu_bus_if  #(.ADDR_W(32), .DATA_W(32)) lsu_b ();
  sram_bus_if #(.ADDR_W(32), .DATA_W(32)) sram_b ();

  lsu_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .lsu         (lsu_b),
    .sram        (sram_b),
    .bridge_busy (busy),
    .rd_count    (rd_count),
    .wr_count    (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: a single set strobe bit is a byte, 0011/1100 a half, the rest a word.
  function automatic logic [1:0] model_size(input bit wr, input logic [3:0] strobe);
    if (!wr)                                        return 2'd2;
    if ($countones(strobe) == 1)                    return 2'd0;
    if (strobe == 4'b0011 || strobe == 4'b1100)     return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] wdata, input logic [1:0] sz,
                                              input logic [31:0] addr);
    int lane;
    lane = 0;
    if (sz == 2'd0) lane = int'(addr % 4);
    if (sz == 2'd1) lane = ((addr % 4) >= 2) ? 2 : 0;
    return wdata << (8 * lane);
  endfunction

  task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strobe, input logic [31:0] rdata,
                     input int addr_wait, input int data_wait, input int ready_delay);
    logic [1:0]  esize;
    logic [31:0] eaddr;
    esize = model_size(wr, strobe);
    eaddr = wr ? addr : (addr & 32'hFFFF_FFFC);
    lsu_b.lsu_req_valid    = 1'b1;
    lsu_b.lsu_req_write_en = wr;
    lsu_b.lsu_req_addr     = addr;
    lsu_b.lsu_req_wdata    = wdata;
    lsu_b.lsu_req_strobe   = strobe;
    lsu_b.lsu_resp_ready   = 1'b0;
    sram_b.sram_addr_ok    = 1'b0;
    for (int i = 0; i < addr_wait; i++) begin
      #1;
      check("stall_ready", {31'b0, lsu_b.lsu_req_ready}, 32'd0);
      check("stall_req", {31'b0, sram_b.sram_req}, 32'd1);
      tick();
    end
    sram_b.sram_addr_ok = 1'b1;
    #1;
    check("accept_ready", {31'b0, lsu_b.lsu_req_ready}, 32'd1);
    check("accept_req", {31'b0, sram_b.sram_req}, 32'd1);
    check("accept_wr", {31'b0, sram_b.sram_wr}, {31'b0, wr});
    check("accept_size", {30'b0, sram_b.sram_size}, {30'b0, esize});
    check("accept_addr", sram_b.sram_addr, eaddr);
    if (wr) check("accept_wdata", sram_b.sram_wdata, model_wdata(wdata, esize, addr));
    tick();
    // Keep pressure on the request side: nothing may be issued while outstanding.
    for (int i = 0; i < data_wait; i++) begin
      #1;
      check("wait_req", {31'b0, sram_b.sram_req}, 32'd0);
      check("wait_ready", {31'b0, lsu_b.lsu_req_ready}, 32'd0);
      check("wait_busy", {31'b0, busy}, 32'd1);
      check("wait_resp_valid", {31'b0, lsu_b.lsu_resp_valid}, 32'd0);
      tick();
    end
    sram_b.sram_data_ok  = 1'b1;
    sram_b.sram_rdata    = rdata;
    lsu_b.lsu_resp_ready = (ready_delay == 0);
    #1;
    check("dok_ready", {31'b0, lsu_b.lsu_req_ready}, 32'd0);
    check("dok_req", {31'b0, sram_b.sram_req}, 32'd0);
    check("dok_resp_valid", {31'b0, lsu_b.lsu_resp_valid}, {31'b0, (!wr && ready_delay == 0)});
    if (!wr && ready_delay == 0) check("dok_resp_data", lsu_b.lsu_resp_data, rdata);
    tick();
    if (!wr && ready_delay > 0) begin
      for (int i = 0; i <= ready_delay; i++) begin
        lsu_b.lsu_resp_ready = (i == ready_delay);
        sram_b.sram_data_ok  = 1'b1;
        sram_b.sram_rdata    = $urandom;
        #1;
        check("hold_valid", {31'b0, lsu_b.lsu_resp_valid}, 32'd1);
        check("hold_data", lsu_b.lsu_resp_data, rdata);
        check("hold_req", {31'b0, sram_b.sram_req}, 32'd0);
        check("hold_busy", {31'b0, busy}, 32'd1);
        tick();
      end
    end
    sram_b.sram_data_ok  = 1'b0;
    sram_b.sram_addr_ok  = 1'b0;
    lsu_b.lsu_req_valid  = 1'b0;
    lsu_b.lsu_resp_ready = 1'b0;
    if (wr) exp_wr++;
    else    exp_rd++;
    #1;
    check("done_rd_count", rd_count, 32'(exp_rd));
    check("done_wr_count", wr_count, 32'(exp_wr));
    check("done_busy", {31'b0, busy}, 32'd0);
    check("done_resp_valid", {31'b0, lsu_b.lsu_resp_valid}, 32'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_req", {31'b0, sram_b.sram_req}, 32'd0);
    check("rst_ready", {31'b0, lsu_b.lsu_req_ready}, 32'd0);
    check("rst_resp_valid", {31'b0, lsu_b.lsu_resp_valid}, 32'd0);
    check("rst_resp_data", lsu_b.lsu_resp_data, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_rd_count", rd_count, 32'd0);
    check("rst_wr_count", wr_count, 32'd0);
  endtask

  initial begin
    logic [3:0] strobes [8];
    strobes = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111, 4'b0110};

    rst                    = 1'b1;
    lsu_b.lsu_req_valid    = 1'b0;
    lsu_b.lsu_req_addr     = '0;
    lsu_b.lsu_req_wdata    = '0;
    lsu_b.lsu_req_strobe   = '0;
    lsu_b.lsu_req_write_en = 1'b0;
    lsu_b.lsu_resp_ready   = 1'b0;
    sram_b.sram_addr_ok    = 1'b0;
    sram_b.sram_data_ok    = 1'b0;
    sram_b.sram_rdata      = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_reset_outputs();

    // Load with one wait cycle, immediate response.
    txn(1'b0, 32'h0000_1004, 32'h0, 4'b0000, 32'hDEAD_BEEF, 0, 1, 0);
    // Load whose response is held until the LSU takes it.
    txn(1'b0, 32'h0000_1008, 32'h0, 4'b0000, 32'h1234_5678, 0, 0, 3);
    // Byte store, then half store, into the upper lanes.
    txn(1'b1, 32'h0000_2003, 32'h0000_00AB, 4'b1000, 32'h0, 0, 0, 0);
    check("sb_lane", model_wdata(32'h0000_00AB, 2'd0, 32'h2003), 32'hAB00_0000);
    txn(1'b1, 32'h0000_2002, 32'h0000_BEEF, 4'b1100, 32'h0, 0, 1, 0);
    check("sb_sh_wr_count", wr_count, 32'd2);
    // Address phase stalled for four cycles.
    txn(1'b0, 32'h0000_3001, 32'h0, 4'b0000, 32'hCAFE_F00D, 4, 2, 0);

    // Spurious data_ok while idle.
    sram_b.sram_data_ok  = 1'b1;
    sram_b.sram_rdata    = 32'h5555_AAAA;
    lsu_b.lsu_resp_ready = 1'b1;
    #1;
    check("spur_resp_valid", {31'b0, lsu_b.lsu_resp_valid}, 32'd0);
    check("spur_busy", {31'b0, busy}, 32'd0);
    tick();
    sram_b.sram_data_ok  = 1'b0;
    lsu_b.lsu_resp_ready = 1'b0;
    #1;
    check("spur_rd_count", rd_count, 32'(exp_rd));
    check("spur_wr_count", wr_count, 32'(exp_wr));
    check("spur_busy_after", {31'b0, busy}, 32'd0);

    // Reset while a load is outstanding.
    lsu_b.lsu_req_valid    = 1'b1;
    lsu_b.lsu_req_write_en = 1'b0;
    lsu_b.lsu_req_addr     = 32'h0000_4000;
    sram_b.sram_addr_ok    = 1'b1;
    tick();
    lsu_b.lsu_req_valid = 1'b0;
    sram_b.sram_addr_ok = 1'b0;
    #1;
    check("mid_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_rd = 0;
    exp_wr = 0;
    #1;
    check_reset_outputs();
    sram_b.sram_data_ok  = 1'b1;
    sram_b.sram_rdata    = 32'h7777_7777;
    lsu_b.lsu_resp_ready = 1'b1;
    #1;
    check("late_dok_resp_valid", {31'b0, lsu_b.lsu_resp_valid}, 32'd0);
    tick();
    sram_b.sram_data_ok  = 1'b0;
    lsu_b.lsu_resp_ready = 1'b0;
    #1;
    check("late_dok_rd_count", rd_count, 32'd0);
    txn(1'b0, 32'h0000_4004, 32'h0, 4'b0000, 32'h0BAD_CAFE, 0, 0, 0);

    // Randomized mix of loads and stores.
    for (int n = 0; n < 40; n++) begin
      bit         wr;
      logic [3:0] strb;
      wr   = $urandom_range(0, 1) == 1;
      strb = 4'b0000;
      if (wr) begin
        if ($urandom_range(0, 3) == 0) strb = 4'($urandom_range(1, 15));
        else                           strb = strobes[$urandom_range(0, 7)];
      end
      txn(wr, $urandom, $urandom, strb, $urandom,
          $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
